// File: rtl/mult_pkg.sv
// Shared types and sizing for the signed 8x8 radix-4 Booth multiplier datapath.
package mult_pkg;

    localparam int PP_W  = 11;
    localparam int N_PP  = 4;
    localparam int OUT_W = 16;
    localparam int ACC_W = 18;
    localparam int CNT_W = 2;

    typedef logic [PP_W-1:0]          pp_row_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Sign-extend a partial-product row to accumulator width.
    function automatic acc_t sext_row(input pp_row_t row);
        return acc_t'({{(ACC_W-PP_W){row[PP_W-1]}}, row});
    endfunction

endpackage

// File: rtl/booth_row_align.sv
// Combinational: sign-extends a Booth row, adds its negate-correction carry
// and shifts it to weight 4^idx.
module booth_row_align
    import mult_pkg::*;
(
    input  logic [PP_W-1:0]  row,
    input  logic             cx,
    input  logic [CNT_W-1:0] idx,
    output acc_t             value
);

    acc_t corr_s;

    assign corr_s = sext_row(row) + acc_t'({{(ACC_W-1){1'b0}}, cx});

    // Scale the corrected row by its radix-4 position.
    always_comb begin
        value = corr_s;
        case (idx)
            2'd0:    value = corr_s;
            2'd1:    value = corr_s <<< 2;
            2'd2:    value = corr_s <<< 4;
            2'd3:    value = corr_s <<< 6;
            default: value = corr_s;
        endcase
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates four Booth partial-product rows over four clocks and returns the
// signed product on a valid/ready handshake. Optional check: BOOTH_PP_CHECK_EN.
module booth_pp_accumulator
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  pp0,
    input  logic [PP_W-1:0]  pp1,
    input  logic [PP_W-1:0]  pp2,
    input  logic [PP_W-1:0]  pp3,
    input  logic             sx1,
    input  logic             sx2,
    input  logic             sx3,
    input  logic             sx4,
    input  logic             cx1,
    input  logic             cx2,
    input  logic             cx3,
    input  logic             cx4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product
`ifdef BOOTH_PP_CHECK_EN
    ,
    output logic             pp_err
`endif
);

    acc_state_t        state_r;
    pp_row_t           pp_r [N_PP];
    logic [N_PP-1:0]   cx_r;
    acc_t              acc_r;
    logic [CNT_W-1:0]  row_cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [OUT_W-1:0]  product_r;

    pp_row_t           row_sel_s;
    logic              cx_sel_s;
    acc_t              row_val_s;
    acc_t              acc_next_s;
    logic              accept_s;

    assign accept_s   = (state_r == IDLE) && in_ready_r && in_valid;
    assign row_sel_s  = pp_r[row_cnt_r];
    assign cx_sel_s   = cx_r[row_cnt_r];
    assign acc_next_s = acc_r + row_val_s;

    booth_row_align u_align (
        .row   (row_sel_s),
        .cx    (cx_sel_s),
        .idx   (row_cnt_r),
        .value (row_val_s)
    );

    // Control FSM with capture, accumulation and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pp_r        <= '{default: '0};
            cx_r        <= '0;
            acc_r       <= '0;
            row_cnt_r   <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            product_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (accept_s) begin
                        pp_r[0]    <= pp0;
                        pp_r[1]    <= pp1;
                        pp_r[2]    <= pp2;
                        pp_r[3]    <= pp3;
                        cx_r       <= {cx4, cx3, cx2, cx1};
                        acc_r      <= '0;
                        row_cnt_r  <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ACC;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ACC: begin
                    in_ready_r <= 1'b0;
                    acc_r      <= acc_next_s;
                    row_cnt_r  <= row_cnt_r + 2'd1;
                    if (row_cnt_r == 2'd3) begin
                        product_r   <= acc_next_s[OUT_W-1:0];
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    in_ready_r <= 1'b0;
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign product   = product_r;

`ifdef BOOTH_PP_CHECK_EN
    logic pp_err_r;
    logic sign_mismatch_s;

    assign sign_mismatch_s = (sx1 != pp0[PP_W-1]) || (sx2 != pp1[PP_W-1]) ||
                             (sx3 != pp2[PP_W-1]) || (sx4 != pp3[PP_W-1]);

    // Sticky sign-consistency flag, sampled only when a bundle is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_err_r <= 1'b0;
        end else if (accept_s && sign_mismatch_s) begin
            pp_err_r <= 1'b1;
        end
    end

    assign pp_err = pp_err_r;
`else
    logic unused_sx_s;
    assign unused_sx_s = ^{sx1, sx2, sx3, sx4};
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed self-checking bench for booth_pp_accumulator (also exercises
// BOOTH_PP_CHECK_EN when that macro is defined).
module tb_booth_pp_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] pp0, pp1, pp2, pp3;
    logic        sx1, sx2, sx3, sx4;
    logic        cx1, cx2, cx3, cx4;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
`ifdef BOOTH_PP_CHECK_EN
    logic        pp_err;
`endif

    int n_checks;
    int n_fail;

    booth_pp_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .sx1       (sx1),
        .sx2       (sx2),
        .sx3       (sx3),
        .sx4       (sx4),
        .cx1       (cx1),
        .cx2       (cx2),
        .cx3       (cx3),
        .cx4       (cx4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
`ifdef BOOTH_PP_CHECK_EN
        ,
        .pp_err    (pp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Present one bundle for a single cycle, then scramble the inputs.
    task automatic send(input logic [10:0] p0, input logic [10:0] p1,
                        input logic [10:0] p2, input logic [10:0] p3,
                        input logic [3:0] c, input logic [3:0] s);
        pp0 = p0; pp1 = p1; pp2 = p2; pp3 = p3;
        {cx4, cx3, cx2, cx1} = c;
        {sx4, sx3, sx2, sx1} = s;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pp0 = 11'h555; pp1 = 11'h2AA; pp2 = 11'h7FF; pp3 = 11'h123;
        {cx4, cx3, cx2, cx1} = 4'hF;
        {sx4, sx3, sx2, sx1} = 4'h5;
    endtask

    task automatic do_product(input string tag,
                              input logic [10:0] p0, input logic [10:0] p1,
                              input logic [10:0] p2, input logic [10:0] p3,
                              input logic [3:0] c, input logic [3:0] s,
                              input logic [15:0] exp);
        out_ready = 1'b1;
        wait_ready();
        send(p0, p1, p2, p3, c, s);
        wait_valid();
        check(tag, {16'd0, product}, {16'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pp0 = 11'd0; pp1 = 11'd0; pp2 = 11'd0; pp3 = 11'd0;
        {cx4, cx3, cx2, cx1} = 4'd0;
        {sx4, sx3, sx2, sx1} = 4'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
`ifdef BOOTH_PP_CHECK_EN
        check("rst_pp_err", {31'd0, pp_err}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 3 x 5 with exact latency
        send(11'd3, 11'd3, 11'd0, 11'd0, 4'h0, 4'h0);
        check("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("t1_early_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check("t1_valid_t5", {31'd0, out_valid}, 32'd1);
        check("t1_product", {16'd0, product}, 32'd15);
        @(negedge clk);
        check("t1_valid_drop_t6", {31'd0, out_valid}, 32'd0);
        check("t1_in_ready_t6", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("t1_in_ready_t7", {31'd0, in_ready}, 32'd1);

        // Signed patterns
        do_product("p_3x_m1", 11'h7FC, 11'd0, 11'd0, 11'd0, 4'h1, 4'h1, 16'hFFFD);
        do_product("p_m128sq", 11'd0, 11'd0, 11'd0, 11'd256, 4'h0, 4'h0, 16'h4000);
        do_product("p_mixed", 11'd2, 11'h7FB, 11'd0, 11'd0, 4'h2, 4'h2, 16'hFFF2);
        do_product("p_row2", 11'd1, 11'd0, 11'd5, 11'd0, 4'h0, 4'h0, 16'd81);

        // Backpressure: 10 stalled cycles, competing in_valid ignored
        out_ready = 1'b0;
        wait_ready();
        send(11'd3, 11'd3, 11'd0, 11'd0, 4'h0, 4'h0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", {31'd0, out_valid}, 32'd1);
            check("bp_product_held", {16'd0, product}, 32'd15);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (i == 2) begin
                pp0 = 11'd1; pp1 = 11'd0; pp2 = 11'd0; pp3 = 11'd0;
                {cx4, cx3, cx2, cx1} = 4'h0;
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_single_transfer", {31'd0, out_valid}, 32'd0);
        begin
            int extra = 0;
            for (int i = 0; i < 12; i++) begin
                if (out_valid === 1'b1) extra++;
                @(negedge clk);
            end
            check("bp_no_extra_output", extra, 32'd0);
        end

        // Reset in the middle of accumulation
        wait_ready();
        send(11'd3, 11'd3, 11'd0, 11'd0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("mid_rst_out_valid2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release_ready", {31'd0, in_ready}, 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid === 1'b1) seen++;
                @(negedge clk);
            end
            check("mid_rst_no_output", seen, 32'd0);
        end
        do_product("mid_rst_next", 11'd3, 11'd3, 11'd0, 11'd0, 4'h0, 4'h0, 16'd15);

`ifdef BOOTH_PP_CHECK_EN
        // Sign-consistency check
        check("chk_clean", {31'd0, pp_err}, 32'd0);
        out_ready = 1'b1;
        wait_ready();
        send(11'h7FC, 11'd0, 11'd0, 11'd0, 4'h0, 4'h0);
        check("chk_err_t1", {31'd0, pp_err}, 32'd1);
        wait_valid();
        check("chk_product", {16'd0, product}, 32'h0000FFFC);
        @(negedge clk);
        do_product("chk_clean_prod", 11'd3, 11'd3, 11'd0, 11'd0, 4'h0, 4'h0, 16'd15);
        check("chk_sticky", {31'd0, pp_err}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("chk_rst_clear", {31'd0, pp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
